demux1x4_behav: RTL and testbench



---
 rtl/demux1x4_behav.sv | 149 ++++++++++++++
 tb/tb_demux1x4_behav.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_behav.sv
// rtl/demux1x4_behav.sv - byte stream to 4-lane unstriper with flush and optional idle auto-flush
//
// Purpose: distributes consecutive valid bytes round-robin into lanes 0..3 and
// publishes each complete (or flushed partial) group with a per-lane valid mask
// and a one-cycle strobe.
//
// Optional feature macro: DEMUX_IDLE_FLUSH_EN (idle-timeout auto-flush of a
// partial group after IDLE_TIMEOUT idle cycles).
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   in        in   incoming byte (DATA_W)
//   valid_in  in   in is valid this cycle
//   flush     in   publish any partially filled group
//   out0..3   out  registered lane bytes, held until next publish
//   validout  out  per-lane valid mask, non-zero only with out_stb
//   out_stb   out  one-cycle group publish strobe
//   lane_ptr  out  next lane to be filled

module demux1x4_behav #(
    parameter int DATA_W       = 8,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              valid_in,
    input  logic              flush,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [3:0]        validout,
    output logic              out_stb,
    output logic [1:0]        lane_ptr
);

    if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_timeout
        $error("IDLE_TIMEOUT must be in 1..255");
    end

    logic [DATA_W-1:0] h_q   [4];
    logic [DATA_W-1:0] h_d   [4];
    logic [DATA_W-1:0] out_q [4];
    logic [DATA_W-1:0] out_d [4];
    logic [3:0]        hv_q, hv_d;
    logic [1:0]        lane_ptr_q, lane_ptr_d;
    logic [3:0]        validout_q, validout_d;
    logic              out_stb_q, out_stb_d;

    // Holding state with the current byte already merged in; a publish in the
    // same cycle uses this view so the arriving byte lands in its lane first.
    logic [DATA_W-1:0] h_fill [4];
    logic [3:0]        hv_fill;
    logic              full_grp;
    logic              flush_req;
    logic              publish;
    logic [3:0]        pub_mask;

`ifdef DEMUX_IDLE_FLUSH_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       idle_hit;

    assign idle_hit  = (idle_cnt_q == 8'(IDLE_TIMEOUT));
    // An explicit flush coinciding with a timeout still yields one publish.
    assign flush_req = flush | idle_hit;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (publish || valid_in) begin
            idle_cnt_d = '0;
        end else if (hv_q != 4'b0000) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign flush_req = flush;
`endif

    always_comb begin
        h_fill  = h_q;
        hv_fill = hv_q;
        if (valid_in) begin
            h_fill[lane_ptr_q]  = in;
            hv_fill[lane_ptr_q] = 1'b1;
        end

        full_grp = valid_in && (lane_ptr_q == 2'd3);
        // A full group takes precedence over flush and always reports all lanes.
        publish  = full_grp || (flush_req && (hv_fill != 4'b0000));
        pub_mask = full_grp ? 4'b1111 : hv_fill;

        h_d        = h_fill;
        hv_d       = hv_fill;
        lane_ptr_d = valid_in ? (lane_ptr_q + 2'd1) : lane_ptr_q;
        out_d      = out_q;
        validout_d = 4'b0000;
        out_stb_d  = 1'b0;

        if (publish) begin
            for (int i = 0; i < 4; i++) begin
                out_d[i] = pub_mask[i] ? h_fill[i] : '0;
                h_d[i]   = '0;
            end
            validout_d = pub_mask;
            out_stb_d  = 1'b1;
            hv_d       = 4'b0000;
            lane_ptr_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                h_q[i]   <= '0;
                out_q[i] <= '0;
            end
            hv_q       <= 4'b0000;
            lane_ptr_q <= 2'd0;
            validout_q <= 4'b0000;
            out_stb_q  <= 1'b0;
        end else begin
            h_q        <= h_d;
            out_q      <= out_d;
            hv_q       <= hv_d;
            lane_ptr_q <= lane_ptr_d;
            validout_q <= validout_d;
            out_stb_q  <= out_stb_d;
        end
    end

    assign out0     = out_q[0];
    assign out1     = out_q[1];
    assign out2     = out_q[2];
    assign out3     = out_q[3];
    assign validout = validout_q;
    assign out_stb  = out_stb_q;
    assign lane_ptr = lane_ptr_q;

endmodule

// File: tb/tb_demux1x4_behav.sv
// tb/tb_demux1x4_behav.sv - scoreboard bench for demux1x4_behav

module tb_demux1x4_behav;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_b;
    logic       valid_in;
    logic       flush;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] validout;
    logic       out_stb;
    logic [1:0] lane_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int last_stb = -100;
    int stb_gap  = 0;

    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    demux1x4_behav #(.DATA_W(8), .IDLE_TIMEOUT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_b),
        .valid_in (valid_in),
        .flush    (flush),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .validout (validout),
        .out_stb  (out_stb),
        .lane_ptr (lane_ptr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void expect_grp(input logic [3:0] m, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d);
        exp_q.push_back({m, d, c, b, a});
    endfunction

    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        valid_in = v;
        in_b     = d;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (out_stb) begin
                stb_gap  = cyc_cnt - last_stb;
                last_stb = cyc_cnt;
                if (exp_q.size() == 0) begin
                    check("unexpected_stb", 64'(out_stb), 64'd0);
                end else begin
                    check("group", 64'({validout, out3, out2, out1, out0}), 64'(exp_q.pop_front()));
                end
            end else begin
                check("vo_no_stb", 64'(validout), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        in_b     = 8'h00;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // reset state
        check("rst_out", 64'({out0, out1, out2, out3}), 64'd0);
        check("rst_validout", 64'(validout), 64'd0);
        check("rst_stb", 64'(out_stb), 64'd0);
        check("rst_lane_ptr", 64'(lane_ptr), 64'd0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("idle_lane_ptr", 64'(lane_ptr), 64'd0);
        check("idle_stb", 64'(out_stb), 64'd0);

        // back-to-back full groups
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'((i + 1) * 8'h11);
            if (i == 3) expect_grp(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
            if (i == 7) expect_grp(4'b1111, 8'h55, 8'h66, 8'h77, 8'h88);
            cyc(1'b1, b, 1'b0);
            if (i == 3) check("full_latency_stb", 64'(out_stb), 64'd1);
            if (i == 1) check("fill_lane_ptr", 64'(lane_ptr), 64'd2);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("stb_gap", 64'(stb_gap), 64'd4);
        check("full_lane_ptr", 64'(lane_ptr), 64'd0);
        check("hold_outs", 64'({out0, out1, out2, out3}), 64'h55667788);

        // partial flush with valid_in low
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0);
        check("part_lane_ptr", 64'(lane_ptr), 64'd2);
        expect_grp(4'b0011, 8'hA1, 8'hA2, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 1'b1);
        check("flush_stb", 64'(out_stb), 64'd1);
        check("flush_lane_ptr", 64'(lane_ptr), 64'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("stb_one_cycle", 64'(out_stb), 64'd0);

        // flush together with a byte, then flush on an empty group
        cyc(1'b1, 8'hB1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        expect_grp(4'b0111, 8'hB1, 8'hB2, 8'hB3, 8'h00);
        cyc(1'b1, 8'hB3, 1'b1);
        check("flush_byte_lane_ptr", 64'(lane_ptr), 64'd0);
        cyc(1'b0, 8'h00, 1'b1);
        check("empty_flush_stb", 64'(out_stb), 64'd0);
        check("empty_flush_lane_ptr", 64'(lane_ptr), 64'd0);

        // full group completing on a flush cycle reports all four lanes
        cyc(1'b1, 8'hF1, 1'b0);
        cyc(1'b1, 8'hF2, 1'b0);
        cyc(1'b1, 8'hF3, 1'b0);
        expect_grp(4'b1111, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
        cyc(1'b1, 8'hF4, 1'b1);

        // reset mid-group discards the partial group
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        check("midrst_lane_ptr", 64'(lane_ptr), 64'd0);
        check("midrst_out0", 64'(out0), 64'd0);
        expect_grp(4'b1111, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hD1 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        // idle behaviour with a single byte pending
        cyc(1'b1, 8'hE1, 1'b0);
`ifdef DEMUX_IDLE_FLUSH_EN
        expect_grp(4'b0001, 8'hE1, 8'h00, 8'h00, 8'h00);
`endif
        repeat (12) cyc(1'b0, 8'h00, 1'b0);
`ifdef DEMUX_IDLE_FLUSH_EN
        check("idle_lane_ptr_after", 64'(lane_ptr), 64'd0);
        check("idle_out0", 64'(out0), 64'hE1);
`else
        check("idle_hold_lane_ptr", 64'(lane_ptr), 64'd1);
        check("idle_hold_out0", 64'(out0), 64'hD1);
        expect_grp(4'b0001, 8'hE1, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 1'b1);
`endif
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
